// File: rtl/mem_word_master.sv
// Word-wide request port to bit-serial banked memory access, LSB first, one bit per cycle.
// Optional write-verify re-read pass is enabled by defining MEM_MASTER_WRVERIFY_EN.
module mem_word_master #(
   parameter  int ADDR_W    = 20,
   parameter  int WORD_LOG2 = 3,
   localparam int WORD_W    = 1 << WORD_LOG2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [1:0]                  req_bank,
   input  logic [ADDR_W-WORD_LOG2-1:0] req_addr,
   input  logic [WORD_W-1:0]           req_wdata,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [WORD_W-1:0]           resp_rdata,
   output logic                        resp_err,
   output logic                        mem_read_rq,
   output logic                        mem_write_rq,
   output logic [1:0]                  mem_sel,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_write_data,
   input  logic                        mem_read_data
);

   // state    | meaning
   // S_IDLE   | waiting for a request, req_ready high
   // S_WRITE  | driving one write bit per cycle
   // S_READ   | sampling one read bit per cycle
   // S_VERIFY | re-reading written bits and comparing (write-verify build only)
   // S_RESP   | holding response until resp_ready
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_VERIFY, S_RESP} state_t;

   localparam logic [WORD_LOG2-1:0] IDX_LAST = WORD_LOG2'(WORD_W - 1);

   state_t                        state_q, state_d;
   logic [WORD_LOG2-1:0]          idx_q;
   logic [1:0]                    bank_q;
   logic [ADDR_W-WORD_LOG2-1:0]   addr_q;
   logic [WORD_W-1:0]             wdata_q;
   logic [WORD_W-1:0]             rdata_q;
   logic                          idx_last;

   assign idx_last = (idx_q == IDX_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (req_valid) state_d = req_write ? S_WRITE : S_READ;
`ifdef MEM_MASTER_WRVERIFY_EN
         S_WRITE:  if (idx_last) state_d = S_VERIFY;
         S_VERIFY: if (idx_last) state_d = S_RESP;
`else
         S_WRITE:  if (idx_last) state_d = S_RESP;
`endif
         S_READ:   if (idx_last) state_d = S_RESP;
         S_RESP:   if (resp_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state_q == S_IDLE);
      resp_valid   = (state_q == S_RESP);
      mem_write_rq = (state_q == S_WRITE);
      mem_read_rq  = (state_q == S_READ) || (state_q == S_VERIFY);
   end

   // Everything below is a register or a decode of registers, so the memory
   // port only moves on state/idx updates.
   assign mem_sel        = bank_q;
   assign mem_addr       = {addr_q, idx_q};
   assign mem_write_data = (state_q == S_WRITE) & wdata_q[idx_q];
   assign resp_rdata     = rdata_q;

`ifdef MEM_MASTER_WRVERIFY_EN
   logic err_q;
   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         bank_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
`ifdef MEM_MASTER_WRVERIFY_EN
         err_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: if (req_valid) begin
               bank_q  <= req_bank;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               idx_q   <= '0;
               rdata_q <= '0;
`ifdef MEM_MASTER_WRVERIFY_EN
               err_q   <= 1'b0;
`endif
            end
            // idx wraps to 0 on the last bit, ready for the verify pass
            S_WRITE: idx_q <= idx_q + WORD_LOG2'(1);
            S_READ: begin
               rdata_q[idx_q] <= mem_read_data;
               idx_q          <= idx_q + WORD_LOG2'(1);
            end
            S_VERIFY: begin
`ifdef MEM_MASTER_WRVERIFY_EN
               if (mem_read_data != wdata_q[idx_q]) err_q <= 1'b1;
`endif
               idx_q <= idx_q + WORD_LOG2'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_word_master.sv
// Bench for mem_word_master: bit-level memory model plus a word-level reference of memory contents.
// Define MEM_MASTER_WRVERIFY_EN for both files to exercise the verify build.
module tb_mem_word_master;

   localparam int ADDR_W = 20;
   localparam int WL2    = 3;
   localparam int WW     = 8;
   localparam int WA     = ADDR_W - WL2;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_write;
   logic [1:0]      req_bank;
   logic [WA-1:0]   req_addr;
   logic [WW-1:0]   req_wdata;
   logic            resp_valid, resp_ready, resp_err;
   logic [WW-1:0]   resp_rdata;
   logic            mem_read_rq, mem_write_rq, mem_write_data, mem_read_data;
   logic [1:0]      mem_sel;
   logic [ADDR_W-1:0] mem_addr;

   mem_word_master #(.ADDR_W(ADDR_W), .WORD_LOG2(WL2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_bank(req_bank), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_read_rq(mem_read_rq), .mem_write_rq(mem_write_rq), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // bit-level memory: 4 banks x 2^20 bits, optional stuck-at-0 bit at address 0x2A
   bit mem_bits [0:(1<<(ADDR_W+2))-1];
   bit stuck_en = 1'b0;

   always @(posedge clk)
      if (mem_write_rq) mem_bits[{mem_sel, mem_addr}] <= mem_write_data;

   always_comb begin
      mem_read_data = 1'b0;
      if (mem_read_rq)
         mem_read_data = (stuck_en && mem_addr == 20'h0002A) ? 1'b0 : mem_bits[{mem_sel, mem_addr}];
   end

   // word-level reference of what memory should hold
   logic [WW-1:0] ref_words [int];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int key_of(input logic [1:0] bank, input logic [WA-1:0] waddr);
      return int'({bank, waddr});
   endfunction

   function automatic logic [WW-1:0] ref_read(input logic [1:0] bank, input logic [WA-1:0] waddr);
      logic [WW-1:0] w;
      int k;
      k = key_of(bank, waddr);
      w = ref_words.exists(k) ? ref_words[k] : '0;
      if (stuck_en && waddr == 17'd5) w[2] = 1'b0;
      return w;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic do_txn(input bit wr, input logic [1:0] bank, input logic [WA-1:0] waddr,
                         input logic [WW-1:0] wd, input int hold);
      logic [WW-1:0] exp_rdata;
      logic          exp_err;
      exp_rdata = wr ? '0 : ref_read(bank, waddr);
      exp_err   = 1'b0;
`ifdef MEM_MASTER_WRVERIFY_EN
      exp_err   = wr && stuck_en && waddr == 17'd5 && wd[2];
`endif
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_write = wr; req_bank = bank; req_addr = waddr; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0; req_wdata = WW'($urandom); req_addr = WA'($urandom); req_bank = 2'($urandom);
      for (int i = 0; i < WW; i++) begin
         chk("wr_rq", mem_write_rq, wr);
         chk("rd_rq", mem_read_rq, !wr);
         chk("sel", mem_sel, bank);
         chk("addr", mem_addr, {waddr, 3'(i)});
         if (wr) chk("wbit", mem_write_data, wd[i]);
         chk("busy_ready", req_ready, 0);
         chk("early_resp", resp_valid, 0);
         @(negedge clk);
      end
      if (wr) ref_words[key_of(bank, waddr)] = wd;
`ifdef MEM_MASTER_WRVERIFY_EN
      if (wr) begin
         for (int i = 0; i < WW; i++) begin
            chk("vfy_rd_rq", mem_read_rq, 1);
            chk("vfy_wr_rq", mem_write_rq, 0);
            chk("vfy_addr", mem_addr, {waddr, 3'(i)});
            chk("vfy_resp", resp_valid, 0);
            @(negedge clk);
         end
      end
`endif
      for (int h = 0; h <= hold; h++) begin
         chk("resp_valid", resp_valid, 1);
         chk("resp_rdata", resp_rdata, exp_rdata);
         chk("resp_err", resp_err, exp_err);
         chk("resp_ready_lo", req_ready, 0);
         chk("resp_strobes", {mem_read_rq, mem_write_rq}, 0);
         chk("resp_sel", mem_sel, bank);
         if (h < hold) @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("post_resp_valid", resp_valid, 0);
      chk("post_req_ready", req_ready, 1);
      chk("idle_sel_hold", mem_sel, bank);
   endtask

   logic [WA-1:0] pool [6];

   initial begin
      logic [WW-1:0] wd;
      logic [WA-1:0] wa;
      logic [1:0]    bk;

      pool[0] = 17'd5; pool[1] = 17'd0; pool[2] = 17'd1;
      pool[3] = 17'h1FFFF; pool[4] = 17'h0AAAA; pool[5] = 17'd6;

      rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_bank = 2'd3;
      req_addr = 17'h12345; req_wdata = 8'hFF; resp_ready = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_req_ready", req_ready, 1);
         chk("rst_strobes", {mem_read_rq, mem_write_rq}, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_sel", mem_sel, 0);
         chk("rst_rdata", resp_rdata, 0);
         chk("rst_err", resp_err, 0);
         chk("rst_wdata", mem_write_data, 0);
      end
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {req_ready, mem_read_rq, mem_write_rq, resp_valid}, 4'b1000);

      do_txn(1'b1, 2'd2, 17'd5, 8'hA5, 0);
      do_txn(1'b0, 2'd2, 17'd5, 8'h00, 5);

      // reset after three write bits: bits 0..2 land in memory, no response
      wd = 8'h3C;
      req_valid = 1'b1; req_write = 1'b1; req_bank = 2'd1; req_addr = 17'd9; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("pre_rst_wr", mem_write_rq, 1);
         if (i < 2) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_wr_rq", mem_write_rq, 0);
      chk("midrst_ready", req_ready, 1);
      chk("midrst_resp", resp_valid, 0);
      chk("midrst_sel", mem_sel, 0);
      chk("midrst_addr", mem_addr, 0);
      begin
         int k;
         logic [WW-1:0] old;
         k = key_of(2'd1, 17'd9);
         old = ref_words.exists(k) ? ref_words[k] : '0;
         ref_words[k] = (old & 8'hF8) | (wd & 8'h07);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("midrst_no_resp", resp_valid, 0);
      end
      do_txn(1'b0, 2'd1, 17'd9, 8'h00, 0);

      for (int n = 0; n < 24; n++) begin
         wa = pool[$urandom_range(0, 5)];
         bk = 2'($urandom);
         do_txn(1'($urandom), bk, wa, WW'($urandom), int'($urandom_range(0, 3)));
      end

      stuck_en = 1'b1;
      do_txn(1'b1, 2'd2, 17'd5, 8'hFF, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_word_master.md
# mem_word_master

Initiator-side controller for the bit-serial banked memory system. It accepts word-wide read/write requests on a valid/ready port and converts each into WORD_W consecutive single-bit accesses: one request strobe, one bit address, and one data bit per cycle, plus a 2-bit bank select. Read bits are reassembled into a word and returned on a valid/ready response port. It sits between the datapath's load/store logic and the memory system's x or w access port.

## Interface
- ADDR_W, 20: bit-address width of the memory port. Use 10 for the x port, 20 for the w port.
- WORD_LOG2, 3: log2 of word width; WORD_W = 1 << WORD_LOG2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted.
- req_write  in  1  1 = write, 0 = read.
- req_bank  in  2  target bank.
- req_addr  in  ADDR_W-WORD_LOG2  word address.
- req_wdata  in  WORD_W  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  WORD_W  read data. 0 for writes.
- resp_err  out  1  write-verify mismatch. Always 0 without the macro.
- mem_read_rq  out  1  memory read strobe.
- mem_write_rq  out  1  memory write strobe.
- mem_sel  out  2  bank select.
- mem_addr  out  ADDR_W  bit address.
- mem_write_data  out  1  write bit.
- mem_read_data  in  1  read bit, combinational from memory during the mem_read_rq cycle.

## Operation
- States: IDLE, WRITE, READ, VERIFY (macro only), RESP.
- req_ready = (state == IDLE). It is combinational from the state register.
- IDLE: on req_valid && req_ready:
  - Latch write flag, bank, address, and data.
  - Clear bit index idx and the error flag.
  - Go to WRITE or READ.
- Bit address: mem_addr = {latched_addr, idx}. Bits go LSB first; idx runs 0..WORD_W-1.
- WRITE:
  - mem_write_rq=1, mem_read_rq=0, mem_write_data = wdata[idx].
  - idx increments each cycle.
  - At idx == WORD_W-1, go to RESP, or to VERIFY with idx cleared when the macro is defined.
- READ:
  - mem_read_rq=1, mem_write_rq=0.
  - On each edge, rdata[idx] <= mem_read_data and idx increments.
  - At idx == WORD_W-1, go to RESP.
- RESP:
  - resp_valid=1, with resp_rdata and resp_err stable.
  - On resp_ready, go to IDLE.
- mem_sel is driven from the latched bank while the block is busy. It holds its last value in IDLE.
- Both strobes are never high together. Both are 0 in IDLE and RESP.
- mem_addr and mem_write_data are registered and change only at state/idx updates.

## Timing
- Reset values:
  - State IDLE, req_ready=1.
  - resp_valid, resp_err, mem_read_rq, mem_write_rq, mem_write_data = 0.
  - mem_sel=0, mem_addr=0, resp_rdata=0, idx=0.
- If a request is accepted at edge T, memory accesses occupy cycles T+1..T+WORD_W.
- resp_valid rises after edge T+WORD_W. With the macro and a write, it rises after edge T+2·WORD_W.
- Minimum turnaround is WORD_W+2 cycles per word (2·WORD_W+2 for verified writes). Requests are not pipelined.
- resp_valid held with resp_ready=0: all response outputs stay stable, and req_ready stays 0.
- resp_valid && resp_ready at edge E: resp_valid=0 and req_ready=1 after E. A new request can be accepted at E+1.
- rst during any state: after that edge, all outputs take their reset values. The in-flight request is dropped with no response. A partially written word stays partially written in memory.
- Address arithmetic: idx is WORD_LOG2 bits and wraps at WORD_W-1. It never carries into the word address.

## Configuration
- MEM_MASTER_WRVERIFY_EN defined:
  - After WRITE, the VERIFY state re-reads the same WORD_W bits with mem_read_rq=1.
  - Each returned bit is compared with wdata[idx]; any mismatch sets resp_err.
  - Then go to RESP.
  - Reads are unaffected and always return resp_err=0.
- Undefined: no VERIFY state, resp_err is tied to 0, and WRITE goes directly to RESP.

## Test plan
All scenarios use WORD_W=8 and ADDR_W=20.
- Reset: rst=1 for 2 cycles with req_valid=1 → req_ready=1, both strobes 0, resp_valid 0, and no request accepted.
- Write 0xA5, bank 2, word address 0x00005 → 8 cycles with mem_write_rq=1, mem_sel=2, mem_addr 0x28..0x2F, and data bits 1,0,1,0,0,1,0,1. resp_valid follows the cycle after the last bit, with resp_rdata=0 and resp_err=0.
- Read back the same word → mem_read_rq=1 for 8 cycles on 0x28..0x2F, then resp_rdata=0xA5.
- Backpressure: resp_ready=0 for 5 cycles → resp_valid, resp_rdata, and req_ready=0 all stable. On resp_ready=1, IDLE follows the next cycle.
- Reset after 3 write bits → next cycle mem_write_rq=0, req_ready=1, and no response.
- Macro defined, memory model with bit 0x2A stuck at 0, write 0xFF to word 0x00005 → 8 write cycles, 8 verify reads, then resp_err=1. Without the macro: resp_err=0 and the response arrives 8 cycles earlier.
